// File: rtl/fetch_pkg.sv
// Shared widths, halt encoding, FSM state type and queue entry layout for the fetch front end.
package fetch_pkg;

    localparam int ADDR_W = 12;
    localparam int INST_W = 19;
    localparam logic [INST_W-1:0] HALT_WORD = 19'h7FFFF;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch front-end bundle: instruction memory port, datapath delivery port and redirect input.
interface fetch_if;
    import fetch_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_valid;
    logic [INST_W-1:0] imem_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc, halted,
        input  imem_valid, imem_data, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, halted,
        output imem_valid, imem_data, inst_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO with a registered head: head outputs come straight from flops and hold when empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             push_entry,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n;
    logic [PTR_W:0]   count_n;
    logic             do_push, do_pop;
    fetch_entry_t     head_n;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);

    // Next head is the freshly pushed word when it lands in the slot that becomes the head.
    always_comb begin
        rd_ptr_n = rd_ptr + PTR_W'(do_pop);
        count_n  = count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        head_n   = head;
        if (count_n != '0) begin
            if (do_push && (rd_ptr_n == wr_ptr)) head_n = push_entry;
            else                                 head_n = mem[rd_ptr_n];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr_n;
            wr_ptr <= wr_ptr + PTR_W'(do_push);
            count  <= count_n;
            head   <= head_n;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns pc, drives imem, fills the prefetch queue, handles redirects.
// Optional halt-word detection is enabled by defining FETCH_HALT_DETECT_EN.
//
// state | meaning
// RUN   | no request outstanding (issues one when the queue has room)
// WAIT  | request outstanding, response will be queued
// DROP  | stale request outstanding after a redirect, response discarded
// HALT  | halt word fetched, no further requests until redirect/reset
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 12'h000
)
(
    input  logic    clk,
    input  logic    rst,
    fetch_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              req_q, req_n;
    logic              push, pop, flush, halt_hit, room;
    logic [CNT_W-1:0]  count, count_end;
    fetch_entry_t      head, push_entry;

    assign flush      = bus.redirect_valid;
    assign pop        = bus.inst_valid && bus.inst_ready;
    assign push       = req_q && bus.imem_valid && (state == ST_WAIT) && !flush;
    assign push_entry = '{pc: pc, data: bus.imem_data};

    // Room is judged on end-of-cycle occupancy so any response issued now is guaranteed a slot.
    assign count_end = count + CNT_W'(push) - CNT_W'(pop);
    assign room      = count_end < CNT_W'(DEPTH);

`ifdef FETCH_HALT_DETECT_EN
    assign halt_hit   = push && (bus.imem_data == HALT_WORD);
    assign bus.halted = (state == ST_HALT);
`else
    assign halt_hit   = 1'b0;
    assign bus.halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_RUN;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = (req_q && !bus.imem_valid) ? ST_DROP : ST_RUN;
        end else begin
            case (state)
                ST_RUN:  if (room) state_n = ST_WAIT;
                ST_WAIT: if (bus.imem_valid) state_n = halt_hit ? ST_HALT : (room ? ST_WAIT : ST_RUN);
                ST_DROP: if (bus.imem_valid) state_n = ST_RUN;
                ST_HALT: state_n = ST_HALT;
                default: state_n = ST_RUN;
            endcase
        end
    end

    always_comb begin
        req_n  = req_q;
        addr_n = addr_q;
        pc_n   = pc;
        if (flush) begin
            pc_n  = bus.redirect_pc;
            req_n = req_q && !bus.imem_valid;
        end else begin
            case (state)
                ST_RUN: begin
                    req_n  = room;
                    addr_n = pc;
                end
                ST_WAIT: if (bus.imem_valid) begin
                    pc_n   = pc + ADDR_W'(1);
                    addr_n = pc + ADDR_W'(1);
                    req_n  = room && !halt_hit;
                end
                ST_DROP: if (bus.imem_valid) req_n = 1'b0;
                default: req_n = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RESET_PC;
            req_q  <= 1'b0;
            addr_q <= RESET_PC;
        end else begin
            pc     <= pc_n;
            req_q  <= req_n;
            addr_q <= addr_n;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_entry (push_entry),
        .head       (head),
        .count      (count)
    );

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = (count != '0);
    assign bus.inst_data  = head.data;
    assign bus.inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized memory latency, ready and redirects against a stream-level model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus();

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(12'h000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    // stream model: instructions come out sequentially from exp_pc, restarting at each redirect target
    int          occ;
    logic [11:0] exp_pc;
    bit          stale, model_halt;
    bit          mem_busy;
    logic [11:0] mem_addr;
    int          mem_wait;
    int          fixed_lat, max_lat, ready_pct, redirect_pct;
    int          force_mode;
    logic [11:0] force_pc;
    bit          fired;
    bit          ovr_en;
    logic [11:0] ovr_addr;
    bit          req6_seen;
    logic [11:0] pop_log[$];
    logic [18:0] pop_dlog[$];
    int          pop_cyc[$];

    function automatic logic [18:0] mem_word(input logic [11:0] a);
        if (ovr_en && a == ovr_addr) return 19'h7FFFF;
        return {7'd0, a} + 19'h100;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    endtask

    task automatic step();
        logic pop, push, acc;
        @(posedge clk);
        #1;
        cycle++;
        bus.imem_valid = 1'b0;
        bus.imem_data  = 19'($urandom);
        if (bus.imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_addr = bus.imem_addr;
                mem_wait = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(max_lat, 0));
            end else begin
                chk("addr_stable", bus.imem_addr, mem_addr);
            end
            if (bus.imem_addr == 12'h006) req6_seen = 1'b1;
            if (mem_wait == 0) begin
                bus.imem_valid = 1'b1;
                bus.imem_data  = mem_word(mem_addr);
            end else begin
                mem_wait--;
            end
        end else if (mem_busy) begin
            chk("req_held", bus.imem_req, 1'b1);
            mem_busy = 1'b0;
        end

        bus.inst_ready     = ($urandom_range(99, 0) < ready_pct);
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 12'($urandom);
        case (force_mode)
            1: if (bus.imem_req && !bus.imem_valid) begin
                bus.redirect_valid = 1'b1; bus.redirect_pc = force_pc; force_mode = 0; fired = 1'b1;
            end
            2: if (bus.imem_valid && bus.inst_valid && bus.inst_ready) begin
                bus.redirect_valid = 1'b1; bus.redirect_pc = force_pc; force_mode = 0; fired = 1'b1;
            end
            3: begin
                bus.redirect_valid = 1'b1; bus.redirect_pc = force_pc; force_mode = 0; fired = 1'b1;
            end
            default: if ($urandom_range(99, 0) < redirect_pct) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc = ($urandom_range(3, 0) == 0) ? 12'hFFC + 12'($urandom_range(3, 0))
                                                               : 12'($urandom);
            end
        endcase

        @(negedge clk);
        pop = bus.inst_valid && bus.inst_ready;
        acc = bus.imem_req && bus.imem_valid;
        chk("inst_valid", bus.inst_valid, occ != 0);
        if (bus.imem_req) chk("room", occ < DEPTH, 1'b1);
        chk("halted", bus.halted, model_halt);
        if (model_halt) chk("halt_noreq", bus.imem_req, 1'b0);
        if (pop) begin
            chk("inst_pc", bus.inst_pc, exp_pc);
            chk("inst_data", bus.inst_data, mem_word(exp_pc));
            pop_log.push_back(bus.inst_pc);
            pop_dlog.push_back(bus.inst_data);
            pop_cyc.push_back(cycle);
            exp_pc = exp_pc + 12'd1;
        end
        push = 1'b0;
        if (acc) begin
            mem_busy = 1'b0;
            if (stale) stale = 1'b0;
            else       push  = 1'b1;
        end
        if (bus.redirect_valid) begin
            stale      = bus.imem_req && !bus.imem_valid;
            occ        = 0;
            exp_pc     = bus.redirect_pc;
            model_halt = 1'b0;
        end else begin
            occ = occ + int'(push) - int'(pop);
`ifdef FETCH_HALT_DETECT_EN
            if (push && bus.imem_data == 19'h7FFFF) model_halt = 1'b1;
`endif
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        bus.imem_valid     = 1'b0;
        bus.imem_data      = '0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        occ = 0; exp_pc = 12'h000; stale = 1'b0; model_halt = 1'b0;
        mem_busy = 1'b0; mem_wait = 0; force_mode = 0; fired = 1'b0; req6_seen = 1'b0;
        pop_log.delete(); pop_dlog.delete(); pop_cyc.delete();
        @(negedge clk);
        chk("rst_req", bus.imem_req, 1'b0);
        chk("rst_addr", bus.imem_addr, 12'h000);
        chk("rst_valid", bus.inst_valid, 1'b0);
        chk("rst_data", bus.inst_data, 19'h0);
        chk("rst_pc", bus.inst_pc, 12'h000);
        chk("rst_halted", bus.halted, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit found;
        fixed_lat = 0; max_lat = 0; ready_pct = 100; redirect_pct = 0;
        ovr_en = 1'b0; ovr_addr = 12'h000;

        // zero-wait streaming at one instruction per cycle
        do_reset();
        step();
        chk("first_req", bus.imem_req, 1'b1);
        chk("first_addr", bus.imem_addr, 12'h000);
        repeat (12) step();
        chk("t1_count", pop_log.size() >= 8, 1'b1);
        for (int i = 0; i < 8 && i < pop_log.size(); i++) begin
            chk("t1_pc", pop_log[i], 12'(i));
            chk("t1_data", pop_dlog[i], 19'h100 + 19'(i));
            chk("t1_b2b", pop_cyc[i], pop_cyc[0] + i);
        end

        // back-pressure fills exactly DEPTH entries and stops requesting
        do_reset();
        ready_pct = 0;
        repeat (10) step();
        chk("t2_occ", occ, DEPTH);
        chk("t2_req", bus.imem_req, 1'b0);
        chk("t2_head", bus.inst_pc, 12'h000);
        ready_pct = 100;
        for (int i = 0; i < 20 && pop_log.size() < 5; i++) step();
        chk("t2_drain", pop_log.size() >= 5, 1'b1);
        for (int i = 0; i < 5 && i < pop_log.size(); i++) chk("t2_pc", pop_log[i], 12'(i));

        // redirect while a slow request is outstanding
        do_reset();
        fixed_lat = 3;
        repeat (6) step();
        force_pc = 12'h0A0; force_mode = 1; fired = 1'b0;
        for (int i = 0; i < 10 && !fired; i++) step();
        chk("t3_fired", fired, 1'b1);
        pop_log.delete(); pop_dlog.delete();
        for (int i = 0; i < 30 && pop_log.size() < 1; i++) step();
        chk("t3_popped", pop_log.size() >= 1, 1'b1);
        if (pop_log.size() >= 1) begin
            chk("t3_pc", pop_log[0], 12'h0A0);
            chk("t3_data", pop_dlog[0], mem_word(12'h0A0));
        end

        // redirect coinciding with a response and a pop
        do_reset();
        fixed_lat = 0;
        repeat (5) step();
        force_pc = 12'h123; force_mode = 2; fired = 1'b0;
        for (int i = 0; i < 10 && !fired; i++) step();
        chk("t4_fired", fired, 1'b1);
        step();
        chk("t4_empty", bus.inst_valid, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            if (bus.imem_req) begin
                chk("t4_addr", bus.imem_addr, 12'h123);
                found = 1'b1;
            end else begin
                step();
            end
        end
        chk("t4_req_seen", found, 1'b1);

        // pc wraps from 0xFFF to 0x000
        do_reset();
        step();
        force_pc = 12'hFFE; force_mode = 3;
        step();
        pop_log.delete(); pop_dlog.delete();
        for (int i = 0; i < 20 && pop_log.size() < 3; i++) step();
        chk("t5_count", pop_log.size() >= 3, 1'b1);
        if (pop_log.size() >= 3) begin
            chk("t5_pc0", pop_log[0], 12'hFFE);
            chk("t5_pc1", pop_log[1], 12'hFFF);
            chk("t5_pc2", pop_log[2], 12'h000);
        end

        // halt word at address 5
        ovr_en = 1'b1; ovr_addr = 12'h005;
        do_reset();
        repeat (25) step();
`ifdef FETCH_HALT_DETECT_EN
        chk("t6_count", pop_log.size(), 6);
        for (int i = 0; i < 6 && i < pop_log.size(); i++) chk("t6_pc", pop_log[i], 12'(i));
        chk("t6_halted", bus.halted, 1'b1);
        chk("t6_no_addr6", req6_seen, 1'b0);
        force_pc = 12'h010; force_mode = 3;
        step();
        step();
        chk("t6_unhalt", bus.halted, 1'b0);
        pop_log.delete(); pop_dlog.delete();
        for (int i = 0; i < 20 && pop_log.size() < 1; i++) step();
        chk("t6_resume", pop_log.size() >= 1, 1'b1);
        if (pop_log.size() >= 1) chk("t6_pc_resume", pop_log[0], 12'h010);
`else
        chk("t6_count", pop_log.size() >= 8, 1'b1);
        if (pop_log.size() >= 6) chk("t6_allones", pop_dlog[5], 19'h7FFFF);
        chk("t6_addr6", req6_seen, 1'b1);
        chk("t6_halted", bus.halted, 1'b0);
`endif
        ovr_en = 1'b0;

        // randomized latency, back-pressure and redirects, with a reset mid-run
        do_reset();
        fixed_lat = -1; max_lat = 3; ready_pct = 70; redirect_pct = 3;
        repeat (1500) step();
        chk("rand_progress_a", pop_log.size() > 200, 1'b1);
        do_reset();
        repeat (1500) step();
        chk("rand_progress_b", pop_log.size() > 200, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that sits directly upstream of the pipelined datapath's IF register. It owns the program counter and drives the instruction memory through a request/valid handshake. Fetched words go into a small prefetch queue, and the datapath drains that queue through a valid/ready handshake. Jump, branch and return redirects from the datapath flush the queue and discard any response still in flight.

## Interface
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- RESET_PC, 12'h000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, held until imem_valid
- imem_addr  out  12  fetch address, stable while imem_req=1
- imem_valid  in  1  response strobe; may assert in the same cycle the request is first presented
- imem_data  in  19  instruction word, qualified by imem_valid
- inst_valid  out  1  queue head valid
- inst_ready  in  1  datapath accepts head
- inst_data  out  19  head instruction
- inst_pc  out  12  address of head instruction
- redirect_valid  in  1  single-cycle redirect (jump/branch/return)
- redirect_pc  in  12  redirect target
- halted  out  1  fetch stopped on halt word (forced 0 when macro absent)

## Operation
- States:
  - RUN: no request outstanding, or issuing one.
  - WAIT: request outstanding.
  - DROP: stale request outstanding after a redirect; its response is discarded.
  - HALT: no further requests.
- Issue condition: imem_req=1 only if occupancy at the end of the current cycle, including a pop this cycle, leaves at least one free slot. This means a response always has room and never overflows the queue.
- Response (imem_valid in WAIT): push {pc, imem_data} into the queue, then pc←pc+1 (12-bit wrap, 12'hFFF→12'h000).
- The request stays asserted back-to-back while space remains, giving a peak rate of one instruction per cycle with zero-wait memory.
- Pop: inst_valid & inst_ready removes the head. Push and pop in the same cycle leave occupancy unchanged.
- Redirect handling:
  - On the edge with redirect_valid, the queue is emptied and pc←redirect_pc.
  - Redirect takes priority over a same-cycle push or pop; that push is discarded.
  - If a request is outstanding and imem_valid is not asserted in the redirect cycle, the next state is DROP. Otherwise the next state is RUN.
  - In DROP, imem_req stays 1 with the old address until imem_valid. The response is discarded, then the unit returns to RUN at redirect_pc.
  - A second redirect while in DROP only updates pc.
- Full queue: imem_req is deasserted. Empty queue: inst_valid=0, and inst_data/inst_pc hold their last values.

## Timing
- Reset values:
  - pc=RESET_PC, state RUN, queue empty.
  - imem_req=0, imem_addr=RESET_PC.
  - inst_valid=0, inst_data=0, inst_pc=0, halted=0.
- The first request is presented in the first cycle after rst deasserts.
- Latency from imem_valid to inst_valid is one edge.
- imem_req and imem_addr are registered. inst_valid, inst_data and inst_pc come directly from the queue registers.
- Reset asserted mid-operation abandons any outstanding request immediately. Memory must tolerate a dropped request.

## Configuration
- FETCH_HALT_DETECT_EN defined:
  - A pushed word equal to 19'h7FFFF is queued normally, then the FSM enters HALT and issues no further requests.
  - halted=1 from the following cycle.
  - The queue drains normally. Only redirect_valid or reset leaves HALT.
- Not defined: the HALT state is absent, halted is tied to 0, and the all-ones word is fetched like any other instruction.

## Structure
- Shared package/header fetch_pkg:
  - ADDR_W=12, INST_W=19, HALT_WORD=19'h7FFFF.
  - FSM state encoding RUN/WAIT/DROP/HALT.
- Sub-module fetch_queue: synchronous FIFO of DEPTH×(ADDR_W+INST_W) with push, pop, flush, count, and head outputs.
- fetch_unit holds the FSM, pc, issue logic, and drop/redirect logic.

## Test plan
- Zero-wait memory returning imem_data=addr+19'h100, with inst_ready=1 → inst_pc 0,1,2,3… on consecutive cycles and inst_data 19'h100,19'h101,….
- inst_ready=0 for 10 cycles → exactly DEPTH=4 entries queued, imem_req=0, and no imem_valid is lost. Releasing ready → pcs 0..3 then 4 in order.
- Memory with 3-cycle latency; redirect_valid with redirect_pc=12'h0A0 during the wait → the stale response is discarded, and the next inst_pc=12'h0A0 with inst_data equal to mem[0xA0].
- Redirect in the same cycle as imem_valid and a pop → queue empty next cycle, and the next request has address redirect_pc.
- pc=12'hFFE, sequential fetch → inst_pc 12'hFFE, 12'hFFF, 12'h000.
- With FETCH_HALT_DETECT_EN, mem[5]=19'h7FFFF → pcs 0..5 delivered, halted=1, and no request for address 6. Then redirect_pc=12'h010 → halted=0 and fetching resumes at 12'h010.
